// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - reset sequencer stage handshake and status bundle
interface reset_sequencer_if #(
    parameter int N_STAGE = 4,
    parameter int RC_W    = 2
);
    logic [N_STAGE-1:0] stage_ready;
    logic [N_STAGE-1:0] stage_rst;
    logic               all_done;
    logic               error;
    logic [2:0]         err_stage;
    logic [RC_W-1:0]    retry_cnt;
    logic               heartbeat;

    modport master (
        input  stage_ready,
        output stage_rst, all_done, error, err_stage, retry_cnt, heartbeat
    );

    modport slave (
        output stage_ready,
        input  stage_rst, all_done, error, err_stage, retry_cnt, heartbeat
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with ready wait, retry, fault and heartbeat
module reset_sequencer #(
    parameter int N_STAGE    = 4,
    parameter int CNT_W      = 24,
    parameter int HOLD_CYC   = 1000000,
    parameter int GAP_CYC    = 1024,
    parameter int TIMEOUT    = 1048575,
    parameter int MAX_RETRY  = 3,
    parameter int HB_BITS    = 24,
    parameter int SIMULATION = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              perst_n,
    reset_sequencer_if.master bus
);
    localparam int HOLD_EFF = (SIMULATION != 0) ? 16 : HOLD_CYC;
    localparam int GAP_EFF  = (SIMULATION != 0) ? 4  : GAP_CYC;
    localparam int TO_EFF   = (SIMULATION != 0) ? 64 : TIMEOUT;
    localparam int HB_EFF   = (SIMULATION != 0) ? 4  : HB_BITS;
    localparam int KW       = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam int RC_W     = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TO_EFF - 1);
    localparam logic [KW-1:0]    LAST    = KW'(N_STAGE - 1);
    localparam logic [RC_W-1:0]  RMAX    = RC_W'(MAX_RETRY);

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    if ((64'(HOLD_EFF) >= (64'd1 << CNT_W)) || (64'(GAP_EFF) >= (64'd1 << CNT_W)) ||
        (64'(TO_EFF) >= (64'd1 << CNT_W))) begin : g_bad_cfg
        $error("reset_sequencer: HOLD/GAP/TIMEOUT does not fit in CNT_W");
    end

    logic               perst_meta, perst_s;
    logic [2:0]         state;
    logic [KW-1:0]      k;
    logic [CNT_W-1:0]   cnt;
    logic [N_STAGE-1:0] stage_rst;
    logic               all_done, error, heartbeat;
    logic [2:0]         err_stage;
    logic [RC_W-1:0]    retry_cnt;
    logic [HB_EFF-1:0]  hb_cnt;

    logic [N_STAGE-1:0] drop_vec, rst_hi;
    logic               drop, fail_req;
    logic [KW-1:0]      drop_idx, fail_idx, k_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perst_meta <= 1'b1;
            perst_s    <= 1'b1;
        end else begin
            perst_meta <= perst_n;
            perst_s    <= perst_meta;
        end
    end

    // A stage counts as dropped only once it has been seen ready: below k while
    // sequencing, any stage once DONE. The lowest dropped index wins.
    always_comb begin
        drop_vec = '0;
        for (int j = 0; j < N_STAGE; j++) begin
            drop_vec[j] = !bus.stage_ready[j] &&
                          ((state == S_DONE) ||
                           (((state == S_WAIT) || (state == S_GAP)) && (KW'(j) < k)));
        end
        drop     = |drop_vec;
        drop_idx = '0;
        for (int j = N_STAGE - 1; j >= 0; j--) begin
            if (drop_vec[j]) drop_idx = KW'(j);
        end
    end

    always_comb begin
        fail_req = 1'b0;
        fail_idx = k;
        if (drop) begin
            fail_req = 1'b1;
            fail_idx = drop_idx;
        end else if ((state == S_WAIT) && !bus.stage_ready[k] && (cnt == TO_M1)) begin
            fail_req = 1'b1;
        end
        for (int i = 0; i < N_STAGE; i++) begin
            rst_hi[i] = (KW'(i) >= fail_idx);
        end
        k_next = k + KW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_HOLD;
            k         <= '0;
            cnt       <= '0;
            stage_rst <= '1;
            all_done  <= 1'b0;
            error     <= 1'b0;
            err_stage <= 3'd0;
            retry_cnt <= '0;
        end else if (!perst_s) begin
            state     <= S_HOLD;
            k         <= '0;
            cnt       <= '0;
            stage_rst <= '1;
            all_done  <= 1'b0;
            error     <= 1'b0;
            err_stage <= 3'd0;
            retry_cnt <= '0;
        end else if (fail_req) begin
            cnt      <= '0;
            all_done <= 1'b0;
            if (retry_cnt < RMAX) begin
                retry_cnt <= retry_cnt + RC_W'(1);
                state     <= S_HOLD;
                k         <= fail_idx;
                stage_rst <= stage_rst | rst_hi;
            end else begin
                state     <= S_FAULT;
                error     <= 1'b1;
                err_stage <= 3'(fail_idx);
                stage_rst <= '1;
            end
        end else begin
            cnt <= (&cnt) ? cnt : cnt + CNT_W'(1);
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_M1) begin
                        stage_rst[k] <= 1'b0;
                        state        <= S_WAIT;
                        cnt          <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.stage_ready[k]) begin
                        cnt <= '0;
                        if (k == LAST) begin
                            state    <= S_DONE;
                            all_done <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_M1) begin
                        stage_rst[k_next] <= 1'b0;
                        k                 <= k_next;
                        state             <= S_WAIT;
                        cnt               <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + HB_EFF'(1);
            if (state == S_DONE) begin
                heartbeat <= 1'b1;
            end else if ((state == S_FAULT) ? (&hb_cnt[HB_EFF-3:0]) : (&hb_cnt)) begin
                heartbeat <= ~heartbeat;
            end
        end
    end

    assign bus.stage_rst = stage_rst;
    assign bus.all_done  = all_done;
    assign bus.error     = error;
    assign bus.err_stage = err_stage;
    assign bus.retry_cnt = retry_cnt;
    assign bus.heartbeat = heartbeat;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic perst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    reset_sequencer_if #(.N_STAGE(4), .RC_W(2)) bus ();

    reset_sequencer #(.N_STAGE(4), .MAX_RETRY(3), .SIMULATION(1)) dut (
        .clk(clk), .reset_n(reset_n), .perst_n(perst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic apply_reset(input logic [3:0] rdy);
        reset_n = 1'b0;
        perst_n = 1'b1;
        bus.stage_ready = rdy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        perst_n = 1'b1;
        bus.stage_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.stage_rst !== 4'b1111) begin n_fail++; $display("FAIL reset_stage_rst: got %b want 1111", bus.stage_rst); end
        n_checks++; if (bus.all_done !== 1'b0) begin n_fail++; $display("FAIL reset_all_done: got %b want 0", bus.all_done); end
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", bus.error); end
        n_checks++; if (bus.err_stage !== 3'd0) begin n_fail++; $display("FAIL reset_err_stage: got %0d want 0", bus.err_stage); end
        n_checks++; if (bus.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_retry_cnt: got %0d want 0", bus.retry_cnt); end
        n_checks++; if (bus.heartbeat !== 1'b0) begin n_fail++; $display("FAIL reset_heartbeat: got %b want 0", bus.heartbeat); end
    endtask

    task automatic test_normal_sequence();
        logic [3:0] exp_rst;
        apply_reset(4'b1111);
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp_rst = {cyc < 31, cyc < 26, cyc < 21, cyc < 16};
            n_checks++; if (bus.stage_rst !== exp_rst) begin n_fail++; $display("FAIL normal_stage_rst cyc %0d: got %b want %b", cyc, bus.stage_rst, exp_rst); end
            n_checks++; if (bus.all_done !== (cyc >= 32)) begin n_fail++; $display("FAIL normal_all_done cyc %0d: got %b want %b", cyc, bus.all_done, cyc >= 32); end
            if (cyc >= 33) begin
                n_checks++; if (bus.heartbeat !== 1'b1) begin n_fail++; $display("FAIL done_heartbeat cyc %0d: got %b want 1", cyc, bus.heartbeat); end
            end
        end
    endtask

    task automatic test_timeout_fault();
        int b;
        int toggles;
        logic prev;
        apply_reset(4'b1011);
        for (int a = 0; a < 3; a++) begin
            b = 26 + 80 * a;
            run_to(b + 63);
            n_checks++; if (bus.stage_rst !== 4'b1000 || bus.retry_cnt !== 2'(a)) begin n_fail++; $display("FAIL pre_timeout_%0d: got rst %b retry %0d want 1000 %0d", a, bus.stage_rst, bus.retry_cnt, a); end
            run_to(b + 64);
            n_checks++; if (bus.stage_rst !== 4'b1100 || bus.retry_cnt !== 2'(a + 1)) begin n_fail++; $display("FAIL retry_%0d: got rst %b retry %0d want 1100 %0d", a, bus.stage_rst, bus.retry_cnt, a + 1); end
            run_to(b + 79);
            n_checks++; if (bus.stage_rst !== 4'b1100) begin n_fail++; $display("FAIL rehold_%0d: got %b want 1100", a, bus.stage_rst); end
            run_to(b + 80);
            n_checks++; if (bus.stage_rst !== 4'b1000) begin n_fail++; $display("FAIL rerelease_%0d: got %b want 1000", a, bus.stage_rst); end
        end
        run_to(329);
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL early_fault: got error %b want 0", bus.error); end
        run_to(330);
        n_checks++; if (bus.error !== 1'b1 || bus.err_stage !== 3'd2) begin n_fail++; $display("FAIL fault_flag: got error %b stage %0d want 1 2", bus.error, bus.err_stage); end
        n_checks++; if (bus.stage_rst !== 4'b1111 || bus.all_done !== 1'b0 || bus.retry_cnt !== 2'd3) begin n_fail++; $display("FAIL fault_outputs: got rst %b done %b retry %0d want 1111 0 3", bus.stage_rst, bus.all_done, bus.retry_cnt); end
        run_to(340);
        prev = bus.heartbeat;
        toggles = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus.heartbeat !== prev) toggles++;
            prev = bus.heartbeat;
        end
        n_checks++; if (toggles != 8) begin n_fail++; $display("FAIL fault_heartbeat: got %0d toggles in 32 cycles want 8", toggles); end
        bus.stage_ready = 4'b1111;
        run_to(480);
        n_checks++; if (bus.error !== 1'b1 || bus.stage_rst !== 4'b1111) begin n_fail++; $display("FAIL fault_sticky: got error %b rst %b want 1 1111", bus.error, bus.stage_rst); end
    endtask

    task automatic test_retry_recover();
        apply_reset(4'b1011);
        run_to(90);
        n_checks++; if (bus.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL recover_retry: got %0d want 1", bus.retry_cnt); end
        bus.stage_ready = 4'b1111;
        run_to(111);
        n_checks++; if (bus.stage_rst !== 4'b0000 || bus.all_done !== 1'b0) begin n_fail++; $display("FAIL recover_last_release: got rst %b done %b want 0000 0", bus.stage_rst, bus.all_done); end
        run_to(112);
        n_checks++; if (bus.all_done !== 1'b1 || bus.error !== 1'b0 || bus.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL recover_done: got done %b error %b retry %0d want 1 0 1", bus.all_done, bus.error, bus.retry_cnt); end
    endtask

    task automatic test_ready_drop();
        apply_reset(4'b1111);
        run_to(40);
        bus.stage_ready = 4'b0101;
        run_to(41);
        n_checks++; if (bus.stage_rst !== 4'b1110 || bus.retry_cnt !== 2'd1 || bus.all_done !== 1'b0) begin n_fail++; $display("FAIL drop_react: got rst %b retry %0d done %b want 1110 1 0", bus.stage_rst, bus.retry_cnt, bus.all_done); end
        run_to(42);
        bus.stage_ready = 4'b1111;
        run_to(56);
        n_checks++; if (bus.stage_rst !== 4'b1110) begin n_fail++; $display("FAIL drop_hold: got %b want 1110", bus.stage_rst); end
        run_to(57);
        n_checks++; if (bus.stage_rst !== 4'b1100) begin n_fail++; $display("FAIL drop_rel1: got %b want 1100", bus.stage_rst); end
        run_to(62);
        n_checks++; if (bus.stage_rst !== 4'b1000) begin n_fail++; $display("FAIL drop_rel2: got %b want 1000", bus.stage_rst); end
        run_to(67);
        n_checks++; if (bus.stage_rst !== 4'b0000 || bus.all_done !== 1'b0) begin n_fail++; $display("FAIL drop_rel3: got rst %b done %b want 0000 0", bus.stage_rst, bus.all_done); end
        run_to(68);
        n_checks++; if (bus.all_done !== 1'b1 || bus.retry_cnt !== 2'd1) begin n_fail++; $display("FAIL drop_done: got done %b retry %0d want 1 1", bus.all_done, bus.retry_cnt); end
    endtask

    task automatic test_perst();
        apply_reset(4'b1011);
        run_to(40);
        perst_n = 1'b0;
        run_to(42);
        n_checks++; if (bus.stage_rst !== 4'b1000) begin n_fail++; $display("FAIL perst_latency: got %b want 1000", bus.stage_rst); end
        run_to(43);
        n_checks++; if (bus.stage_rst !== 4'b1111 || bus.retry_cnt !== 2'd0) begin n_fail++; $display("FAIL perst_wait_clear: got rst %b retry %0d want 1111 0", bus.stage_rst, bus.retry_cnt); end
        run_to(50);
        perst_n = 1'b1;
        run_to(67);
        n_checks++; if (bus.stage_rst !== 4'b1111) begin n_fail++; $display("FAIL perst_rehold: got %b want 1111", bus.stage_rst); end
        run_to(68);
        n_checks++; if (bus.stage_rst !== 4'b1110) begin n_fail++; $display("FAIL perst_restart: got %b want 1110", bus.stage_rst); end
        run_to(400);
        n_checks++; if (bus.error !== 1'b1 || bus.err_stage !== 3'd2) begin n_fail++; $display("FAIL perst_fault_setup: got error %b stage %0d want 1 2", bus.error, bus.err_stage); end
        perst_n = 1'b0;
        run_to(402);
        n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL perst_fault_latency: got error %b want 1", bus.error); end
        run_to(403);
        n_checks++; if (bus.error !== 1'b0 || bus.err_stage !== 3'd0 || bus.retry_cnt !== 2'd0 || bus.stage_rst !== 4'b1111) begin n_fail++; $display("FAIL perst_fault_clear: got error %b stage %0d retry %0d rst %b want 0 0 0 1111", bus.error, bus.err_stage, bus.retry_cnt, bus.stage_rst); end
        bus.stage_ready = 4'b1111;
        run_to(405);
        perst_n = 1'b1;
        run_to(423);
        n_checks++; if (bus.stage_rst !== 4'b1110) begin n_fail++; $display("FAIL perst_fault_restart: got %b want 1110", bus.stage_rst); end
        run_to(439);
        n_checks++; if (bus.all_done !== 1'b1 || bus.error !== 1'b0) begin n_fail++; $display("FAIL perst_fault_done: got done %b error %b want 1 0", bus.all_done, bus.error); end
    endtask

    task automatic test_async_reset();
        apply_reset(4'b1111);
        run_to(18);
        n_checks++; if (bus.stage_rst !== 4'b1110 || bus.heartbeat !== 1'b1) begin n_fail++; $display("FAIL async_setup: got rst %b hb %b want 1110 1", bus.stage_rst, bus.heartbeat); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.stage_rst !== 4'b1111 || bus.heartbeat !== 1'b0 || bus.all_done !== 1'b0) begin n_fail++; $display("FAIL async_reset: got rst %b hb %b done %b want 1111 0 0", bus.stage_rst, bus.heartbeat, bus.all_done); end
    endtask

    initial begin
        bus.stage_ready = 4'b1111;
        test_reset();
        test_normal_sequence();
        test_timeout_fault();
        test_retry_recover();
        test_ready_drop();
        test_perst();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
